// File: rtl/uart_pkg.sv
// Shared UART definitions used by both ends of the serial link.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Receiver sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // XOR-reduce of a data word. Even parity over {data, parity_bit} means this
  // equals the parity bit; the transmitter uses it to generate the bit.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input. The reset value is
// configurable so idle-high lines come out of reset in their idle state.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the async input, then re-register to let metastability settle.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 8 data bits LSB first, optional even/odd parity, one
// stop bit. Bit timing comes from a fixed CLKS_PER_BIT divider; the start bit
// is qualified at its midpoint and every later bit is sampled one bit period
// after the previous sample.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on the synchronised rx
// START     | counting to mid start bit to reject glitches
// DATA      | sampling the 8 data bits, one per bit period
// PARITY    | sampling the parity bit and recording a mismatch
// STOP      | sampling the stop bit; decides between delivery and framing error
// WAIT_HIGH | framing error seen, waiting for the line to return high (break)
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] Data_out,
  output logic                 received,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad;
  logic                 deliver_good;
  logic                 deliver_fe;

  uart_sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  // Frame sequencer. The stop-bit decision is latched into deliver_* so the
  // strobes appear one cycle after the stop sample, while the FSM is already
  // back in IDLE and able to catch a start edge at the nominal stop-bit end.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      par_bad       <= 1'b0;
      deliver_good  <= 1'b0;
      deliver_fe    <= 1'b0;
      Data_out      <= '0;
      received      <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      received      <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      deliver_good  <= 1'b0;
      deliver_fe    <= 1'b0;

      // Bad parity still delivers the byte; the error only flags it.
      if (deliver_good) begin
        Data_out     <= shift;
        received     <= 1'b1;
        parity_error <= par_bad;
      end
      if (deliver_fe) begin
        framing_error <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            clk_cnt <= '0;
            busy    <= 1'b1;
            state   <= START;
          end
        end

        START: begin
          if (clk_cnt == CNT_HALF) begin
            if (rx_s) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              clk_cnt <= '0;
              bit_idx <= '0;
              par_bad <= 1'b0;
              state   <= DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == LAST_BIT) begin
              state <= PARITY_EN ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        PARITY: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            par_bad <= (parity_of(shift) ^ rx_s) != PARITY_ODD;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              deliver_good <= 1'b1;
              busy         <= 1'b0;
              state        <= IDLE;
            end else begin
              deliver_fe <= 1'b1;
              state      <= WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        // A held-low line must not be mistaken for a stream of start bits.
        WAIT_HIGH: begin
          if (rx_s) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three instances cover 8N1 at 2 clocks/bit, 8N1 at
// 4 clocks/bit and 8E1 at 2 clocks/bit. Expected bytes, parity flags and
// strobe timing come from the frame definition and the latency formula.
module tb_uart_rx_frame;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_l   [3];
  logic [7:0] dout   [3];
  logic       rcv    [3];
  logic       fe     [3];
  logic       perr   [3];
  logic       busy   [3];

  always #5 clock = ~clock;

  uart_rx_frame #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
    .clock(clock), .reset(reset), .rx(rx_l[0]), .Data_out(dout[0]),
    .received(rcv[0]), .framing_error(fe[0]), .parity_error(perr[0]), .busy(busy[0]));

  uart_rx_frame #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_b (
    .clock(clock), .reset(reset), .rx(rx_l[1]), .Data_out(dout[1]),
    .received(rcv[1]), .framing_error(fe[1]), .parity_error(perr[1]), .busy(busy[1]));

  uart_rx_frame #(.CLKS_PER_BIT(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_c (
    .clock(clock), .reset(reset), .rx(rx_l[2]), .Data_out(dout[2]),
    .received(rcv[2]), .framing_error(fe[2]), .parity_error(perr[2]), .busy(busy[2]));

  // Latency (9+PARITY_EN)*CLKS_PER_BIT + (CLKS_PER_BIT-1)/2 + 4 per instance.
  localparam int LAT_A = 9 * 2 + 0 + 4;
  localparam int LAT_B = 9 * 4 + 1 + 4;
  localparam int LAT_C = 10 * 2 + 0 + 4;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Event recorder: every strobe seen by each instance, sampled mid-cycle.
  logic [7:0] rdata     [3][64];
  int         rcyc      [3][64];
  logic       rperr     [3][64];
  int         rcv_cnt   [3] = '{0, 0, 0};
  int         fe_cnt    [3] = '{0, 0, 0};
  int         fe_cyc    [3] = '{0, 0, 0};
  int         stray     [3] = '{0, 0, 0};
  int         excl      [3] = '{0, 0, 0};
  int         busy_rise [3] = '{0, 0, 0};
  logic       busy_prev [3] = '{1'b0, 1'b0, 1'b0};

  always @(negedge clock) begin
    for (int d = 0; d < 3; d++) begin
      busy_prev[d] <= busy[d];
      if (busy[d] === 1'b1 && busy_prev[d] === 1'b0) busy_rise[d] <= busy_rise[d] + 1;
      if (rcv[d] === 1'b1) begin
        rdata[d][rcv_cnt[d] % 64] <= dout[d];
        rcyc[d][rcv_cnt[d] % 64]  <= cyc;
        rperr[d][rcv_cnt[d] % 64] <= perr[d];
        rcv_cnt[d]                <= rcv_cnt[d] + 1;
      end
      if (fe[d] === 1'b1) begin
        fe_cnt[d] <= fe_cnt[d] + 1;
        fe_cyc[d] <= cyc;
      end
      if (perr[d] === 1'b1 && rcv[d] !== 1'b1) stray[d] <= stray[d] + 1;
      if ((rcv[d] === 1'b1 && fe[d] === 1'b1) || (fe[d] === 1'b1 && perr[d] === 1'b1))
        excl[d] <= excl[d] + 1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int rd_idx [3] = '{0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lat(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs >= exp - 1 && obs <= exp + 1) else begin
      n_fail++;
      $error("FAIL %s observed_cycle=%0d expected_cycle=%0d(+-1)", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input int d, input logic v, input int cpb);
    rx_l[d] = v;
    repeat (cpb) @(negedge clock);
  endtask

  // Drives one frame starting at the current negedge; start is the cycle
  // count at the first clock edge that sees the start bit on the pin.
  task automatic send(input int d, input int cpb, input logic [7:0] data,
                      input logic has_par, input logic par_bit,
                      input logic stop_bit, output int start);
    start = cyc + 1;
    bit_time(d, 1'b0, cpb);
    for (int i = 0; i < 8; i++) bit_time(d, data[i], cpb);
    if (has_par) bit_time(d, par_bit, cpb);
    bit_time(d, stop_bit, cpb);
  endtask

  task automatic pop_rx(input int d, input logic [7:0] exp_data, input logic exp_perr,
                        input int exp_cyc, input string tag);
    int k;
    chk({tag, "_avail"}, 32'(rcv_cnt[d] > rd_idx[d]), 32'd1);
    if (rcv_cnt[d] > rd_idx[d]) begin
      k = rd_idx[d] % 64;
      chk({tag, "_data"}, 32'(rdata[d][k]), 32'(exp_data));
      chk({tag, "_perr"}, 32'(rperr[d][k]), 32'(exp_perr));
      chk_lat({tag, "_lat"}, rcyc[d][k], exp_cyc);
      rd_idx[d]++;
    end
  endtask

  task automatic chk_none(input int d, input string tag);
    chk({tag, "_extra_rx"}, 32'(rcv_cnt[d] - rd_idx[d]), 32'd0);
  endtask

  task automatic chk_reset_outs(input int d, input string tag);
    chk({tag, "_dout"}, 32'(dout[d]), 32'd0);
    chk({tag, "_rcv"},  32'(rcv[d]),  32'd0);
    chk({tag, "_fe"},   32'(fe[d]),   32'd0);
    chk({tag, "_perr"}, 32'(perr[d]), 32'd0);
    chk({tag, "_busy"}, 32'(busy[d]), 32'd0);
  endtask

  logic [7:0] eb [8];
  logic       ep [8];
  int         es [8];

  initial begin
    int s, s1, s2, fe0, br;
    logic [7:0] b;
    logic pb;

    rx_l[0] = 1'b1;
    rx_l[1] = 1'b1;
    rx_l[2] = 1'b1;
    reset   = 1'b1;
    repeat (4) @(negedge clock);
    for (int d = 0; d < 3; d++) chk_reset_outs(d, "reset");
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Good 8N1 frame.
    send(0, 2, 8'hCB, 1'b0, 1'b0, 1'b1, s);
    repeat (30) @(negedge clock);
    pop_rx(0, 8'hCB, 1'b0, s + LAT_A, "good_cb");
    chk_none(0, "good_cb");
    chk("good_cb_fe", 32'(fe_cnt[0]), 32'd0);
    chk("good_cb_busy", 32'(busy[0]), 32'd0);

    // Back-to-back frames with no idle between them.
    send(0, 2, 8'h93, 1'b0, 1'b0, 1'b1, s1);
    send(0, 2, 8'h68, 1'b0, 1'b0, 1'b1, s2);
    repeat (30) @(negedge clock);
    pop_rx(0, 8'h93, 1'b0, s1 + LAT_A, "b2b_93");
    pop_rx(0, 8'h68, 1'b0, s2 + LAT_A, "b2b_68");
    chk_none(0, "b2b");

    // Framing error followed by a held-low line.
    fe0 = fe_cnt[0];
    send(0, 2, 8'h3C, 1'b0, 1'b0, 1'b0, s);
    repeat (30) @(negedge clock);
    chk("fe_count", 32'(fe_cnt[0]), 32'(fe0 + 1));
    chk_lat("fe_lat", fe_cyc[0], s + LAT_A);
    chk("fe_dout_hold", 32'(dout[0]), 32'h68);
    chk("fe_busy_low_line", 32'(busy[0]), 32'd1);
    chk_none(0, "fe_low");
    rx_l[0] = 1'b1;
    repeat (10) @(negedge clock);
    chk("fe_busy_after_high", 32'(busy[0]), 32'd0);
    chk("fe_count_after_high", 32'(fe_cnt[0]), 32'(fe0 + 1));
    chk_none(0, "fe_high");

    // Reset in the middle of a frame of 8'hFF.
    fe0 = fe_cnt[0];
    bit_time(0, 1'b0, 2);
    for (int i = 0; i < 3; i++) bit_time(0, 1'b1, 2);
    rx_l[0] = 1'b1;
    @(negedge clock);
    chk("midrst_busy_before", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk_reset_outs(0, "midrst");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) bit_time(0, 1'b1, 2);
    repeat (30) @(negedge clock);
    chk_none(0, "midrst_abort");
    chk("midrst_fe", 32'(fe_cnt[0]), 32'(fe0));
    send(0, 2, 8'h55, 1'b0, 1'b0, 1'b1, s);
    repeat (30) @(negedge clock);
    pop_rx(0, 8'h55, 1'b0, s + LAT_A, "midrst_55");

    // Random 8N1 frames with short random gaps (including none).
    for (int i = 0; i < 6; i++) begin
      eb[i] = 8'($urandom);
      send(0, 2, eb[i], 1'b0, 1'b0, 1'b1, es[i]);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    repeat (30) @(negedge clock);
    for (int i = 0; i < 6; i++) pop_rx(0, eb[i], 1'b0, es[i] + LAT_A, "rand_a");
    chk_none(0, "rand_a");

    // One-clock start glitch at 4 clocks per bit.
    br = busy_rise[1];
    rx_l[1] = 1'b0;
    @(negedge clock);
    rx_l[1] = 1'b1;
    repeat (20) @(negedge clock);
    chk("glitch_busy_pulse", 32'(busy_rise[1]), 32'(br + 1));
    chk("glitch_busy_now", 32'(busy[1]), 32'd0);
    chk("glitch_fe", 32'(fe_cnt[1]), 32'd0);
    chk_none(1, "glitch");
    send(1, 4, 8'hA5, 1'b0, 1'b0, 1'b1, s);
    repeat (50) @(negedge clock);
    pop_rx(1, 8'hA5, 1'b0, s + LAT_B, "glitch_a5");

    for (int i = 0; i < 4; i++) begin
      eb[i] = 8'($urandom);
      send(1, 4, eb[i], 1'b0, 1'b0, 1'b1, es[i]);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    repeat (50) @(negedge clock);
    for (int i = 0; i < 4; i++) pop_rx(1, eb[i], 1'b0, es[i] + LAT_B, "rand_b");
    chk_none(1, "rand_b");

    // Even parity: 8'h07 has three ones, so the correct parity bit is 1.
    send(2, 2, 8'h07, 1'b1, 1'b1, 1'b1, s);
    repeat (30) @(negedge clock);
    pop_rx(2, 8'h07, 1'b0, s + LAT_C, "par_ok");
    send(2, 2, 8'h07, 1'b1, 1'b0, 1'b1, s);
    repeat (30) @(negedge clock);
    pop_rx(2, 8'h07, 1'b1, s + LAT_C, "par_bad");

    for (int i = 0; i < 6; i++) begin
      b     = 8'($urandom);
      pb    = 1'($urandom);
      eb[i] = b;
      ep[i] = ((($countones(b) + int'(pb)) % 2) != 0);
      send(2, 2, b, 1'b1, pb, 1'b1, es[i]);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    repeat (30) @(negedge clock);
    for (int i = 0; i < 6; i++) pop_rx(2, eb[i], ep[i], es[i] + LAT_C, "rand_c");
    chk_none(2, "rand_c");
    chk("par_fe", 32'(fe_cnt[2]), 32'd0);

    // Strobe exclusivity over the whole run.
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("stray_perr_%0d", d), 32'(stray[d]), 32'd0);
      chk($sformatf("strobe_excl_%0d", d), 32'(excl[d]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
